moddiv_core: RTL and testbench

- Sequential modular divider for the Montgomery-ladder ECC engine. Computes z = x / y mod p with a binary extended-Euclid algorithm, one reduction step per cycle.
- Sits downstream of the ladder's projective-to-affine conversion: consumes the final X and Z coordinates and produces the affine x.
- Uses the same start_div/finish_div handshake and the IDLE/PRE/LOOP/FINISH state skeleton as the existing division control.

---
 rtl/moddiv_core_if.sv | 24 ++
 rtl/moddiv_core.sv | 127 ++++++++++++
 tb/tb_moddiv_core.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/moddiv_core_if.sv
// rtl/moddiv_core_if.sv - start/finish handshake and operand bus for the modular divider
// Signals: start_div, x, y, p (requester -> divider); z, finish_div, err, busy (divider -> requester).
interface moddiv_core_if #(
    parameter int DATA_LEN = 256
);
    logic                start_div;
    logic [DATA_LEN-1:0] x;
    logic [DATA_LEN-1:0] y;
    logic [DATA_LEN-1:0] p;
    logic [DATA_LEN-1:0] z;
    logic                finish_div;
    logic                err;
    logic                busy;

    modport master (
        output start_div, x, y, p,
        input  z, finish_div, err, busy
    );

    modport slave (
        input  start_div, x, y, p,
        output z, finish_div, err, busy
    );
endinterface

// File: rtl/moddiv_core.sv
// rtl/moddiv_core.sv - sequential z = x / y mod p divider, binary extended Euclid, one step per cycle
// Ports: clk, rst_n (async active-low); div (slave): start_div, x, y, p in; z, finish_div, err, busy out.
module moddiv_core #(
    parameter int DATA_LEN = 256,
    parameter int CNT_W    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    moddiv_core_if.slave  div
);
    typedef enum logic [1:0] {IDLE, PRE, LOOP, FINISH} state_t;

    localparam logic [CNT_W-1:0] CAP = CNT_W'(4 * DATA_LEN);

    state_t              state_q, state_d;
    logic [DATA_LEN-1:0] x_q, y_q, p_q;
    logic [DATA_LEN-1:0] u_q, v_q, a_q, b_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_LEN-1:0] z_q;
    logic                err_q;

    logic                u_one, v_one, cap_hit;
    logic [DATA_LEN:0]   a_sum, b_sum, ab_diff, ba_diff;
    logic [DATA_LEN-1:0] a_half, b_half;

    assign u_one   = (u_q == DATA_LEN'(1));
    assign v_one   = (v_q == DATA_LEN'(1));
    assign cap_hit = (cnt_q == CAP);

    // One extra bit keeps A+p and the borrow of A-B visible.
    assign a_sum   = {1'b0, a_q} + {1'b0, p_q};
    assign b_sum   = {1'b0, b_q} + {1'b0, p_q};
    assign a_half  = a_q[0] ? a_sum[DATA_LEN:1] : (a_q >> 1);
    assign b_half  = b_q[0] ? b_sum[DATA_LEN:1] : (b_q >> 1);
    assign ab_diff = {1'b0, a_q} - {1'b0, b_q};
    assign ba_diff = {1'b0, b_q} - {1'b0, a_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div.start_div) state_d = PRE;
            PRE:     state_d = (y_q == '0) ? FINISH : LOOP;
            LOOP:    if (u_one || v_one || cap_hit) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div.busy       = (state_q != IDLE);
        div.finish_div = (state_q == FINISH);
        div.z          = z_q;
        div.err        = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            p_q   <= '0;
            u_q   <= '0;
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            z_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div.start_div) begin
                        x_q <= div.x;
                        y_q <= div.y;
                        p_q <= div.p;
                    end
                end
                PRE: begin
                    u_q   <= y_q;
                    v_q   <= p_q;
                    a_q   <= x_q;
                    b_q   <= '0;
                    cnt_q <= '0;
                    if (y_q == '0) begin
                        z_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                LOOP: begin
                    if (u_one || v_one) begin
                        z_q   <= u_one ? a_q : b_q;
                        err_q <= 1'b0;
                    end else if (cap_hit) begin
                        z_q   <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (!u_q[0]) begin
                            u_q <= u_q >> 1;
                            a_q <= a_half;
                        end else if (!v_q[0]) begin
                            v_q <= v_q >> 1;
                            b_q <= b_half;
                        end else if (u_q >= v_q) begin
                            u_q <= u_q - v_q;
                            // On borrow the wrapped low bits plus p land back in [0,p).
                            a_q <= ab_diff[DATA_LEN] ? (ab_diff[DATA_LEN-1:0] + p_q)
                                                     : ab_diff[DATA_LEN-1:0];
                        end else begin
                            v_q <= v_q - u_q;
                            b_q <= ba_diff[DATA_LEN] ? (ba_diff[DATA_LEN-1:0] + p_q)
                                                     : ba_diff[DATA_LEN-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_moddiv_core.sv
// tb/tb_moddiv_core.sv - scoreboard bench for moddiv_core: directed vectors, modexp-checked sweep, reset abort
module tb_moddiv_core;
    localparam int DL = 16;

    logic clk;
    logic rst_n;

    moddiv_core_if #(.DATA_LEN(DL)) div ();

    moddiv_core #(.DATA_LEN(DL), .CNT_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DL-1:0] z;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_fin = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint modexp(input longint b, input longint e, input longint m);
        longint r = 1;
        b = b % m;
        while (e > 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    // Monitor: every finish_div pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (div.finish_div) begin
                n_cmp++;
                if (prev_fin) begin
                    n_bad++;
                    $display("FAIL fin_pulse: finish_div high %0d cycles, expected 1", 2);
                end
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_finish: got finish_div=1 expected no pending operation");
                end else begin
                    e = sb_q.pop_front();
                    chk("z", 32'(div.z), 32'(e.z));
                    chk("err", 32'(div.err), 32'(e.err));
                end
            end
            prev_fin <= div.finish_div;
        end else begin
            prev_fin <= 1'b0;
        end
    end

    // exp_n: cycles from the sampling edge of start_div to the finish_div cycle
    // (2 + steps; 1 for y==0); negative means only the step-cap bound is checked.
    task automatic run(input logic [DL-1:0] px, input logic [DL-1:0] py, input logic [DL-1:0] pp,
                       input logic [DL-1:0] ez, input logic ee, input int exp_n, input bit poke);
        int n;
        bit done;
        exp_t e;
        @(negedge clk);
        div.x = px;
        div.y = py;
        div.p = pp;
        div.start_div = 1'b1;
        e.z = ez;
        e.err = ee;
        sb_q.push_back(e);
        @(posedge clk);
        n = 0;
        done = 1'b0;
        @(negedge clk);
        div.start_div = 1'b0;
        div.x = DL'($urandom);
        div.y = DL'($urandom);
        div.p = DL'($urandom);
        while (!done && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (div.finish_div) done = 1'b1;
            else if (poke && n == 3) div.start_div = 1'b1;
            else div.start_div = 1'b0;
        end
        div.start_div = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no finish_div in %0d cycles expected one", n);
            sb_q.delete();
        end else begin
            if (exp_n >= 0) chk("latency", 32'(n), 32'(exp_n));
            else            chk("lat_bound", 32'(n <= 3 + 4 * DL), 32'd1);
            @(posedge clk);
            #1;
            chk("busy_drop", {30'd0, div.busy, div.finish_div}, 32'd0);
        end
    endtask

    initial begin
        logic [DL-1:0] rx, ry, rz;
        div.start_div = 1'b0;
        div.x = '0;
        div.y = '0;
        div.p = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_z", 32'(div.z), 32'd0);
        chk("rst_fin", 32'(div.finish_div), 32'd0);
        chk("rst_err", 32'(div.err), 32'd0);
        chk("rst_busy", 32'(div.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(16'd3, 16'd2, 16'd7, 16'd5, 1'b0, 3, 1'b0);
        run(16'd1, 16'd3, 16'd7, 16'd5, 1'b0, -1, 1'b0);
        run(16'd1, 16'd2, 16'd251, 16'd126, 1'b0, -1, 1'b0);
        run(16'd6, 16'd1, 16'd7, 16'd6, 1'b0, 2, 1'b0);
        run(16'd0, 16'd5, 16'd7, 16'd0, 1'b0, -1, 1'b0);
        run(16'd4, 16'd0, 16'd7, 16'd0, 1'b1, 1, 1'b0);
        run(16'd5, 16'd1, 16'd7, 16'd5, 1'b0, 2, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ry = DL'($urandom_range(1, 65520));
            rx = DL'($urandom_range(0, 65520));
            rz = DL'((longint'(rx) * modexp(longint'(ry), 65519, 65521)) % 65521);
            run(rx, ry, 16'd65521, rz, 1'b0, -1, (i % 5) == 0);
        end

        // Abort mid-LOOP: no pulse, outputs cleared at once.
        @(negedge clk);
        div.x = 16'd10;
        div.y = 16'd200;
        div.p = 16'd251;
        div.start_div = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div.start_div = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_z", 32'(div.z), 32'd0);
        chk("abort_fin", 32'(div.finish_div), 32'd0);
        chk("abort_err", 32'(div.err), 32'd0);
        chk("abort_busy", 32'(div.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(16'd10, 16'd200, 16'd251, 16'd113, 1'b0, -1, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
